// File: rtl/perf_mon_pkg.sv
// Shared types and helpers for the performance event monitor.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  // The cycle counter always sits right after the event channels in the read space.
  function automatic int cycle_idx(input int num_ch);
    return num_ch;
  endfunction

  // Increment v as a w-bit value, sticking at all-ones.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max;
    max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max) ? max : v + 64'd1;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// CNT_W saturating counter with synchronous clear and sticky overflow flag.
module perf_sat_counter
  import perf_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic at_max;
  assign at_max = &cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= CNT_W'(sat_inc(64'(cnt), CNT_W));
      if (at_max) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_event_monitor.sv
// Pipeline perf monitor: NUM_CH event counters + cycle counter, limit FSM,
// atomic snapshot bank and 1-cycle read port. Optional: PERF_MON_THRESH_IRQ_EN.
module perf_event_monitor
  import perf_mon_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 32,
  localparam int IDX_W  = $clog2(NUM_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [CNT_W-1:0]  limit_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              snap_i,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
`ifdef PERF_MON_THRESH_IRQ_EN
  input  logic [CNT_W-1:0]  thresh_i,
  input  logic [IDX_W-1:0]  thresh_sel_i,
  output logic              irq_o,
`endif
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic [NUM_CH:0]   ovf_o,
  output logic [1:0]        state_o,
  output logic              done_o
);

  localparam int CYCLE_IDX = cycle_idx(NUM_CH);

  mon_state_e                 state, state_nxt;
  logic [NUM_CH:0][CNT_W-1:0] live, bank;
  logic [NUM_CH:0]            inc;
  logic [CNT_W-1:0]           cyc_nxt, rd_mux;
  logic                       cnt_en, hit;

  // Counting follows start_i directly, so the IDLE/PAUSE->RUN edge already counts.
  assign cnt_en = start_i && (state != ST_DONE);
  assign inc    = {cnt_en, event_i & {NUM_CH{cnt_en}}};

  for (genvar k = 0; k <= NUM_CH; k++) begin : g_cnt
    perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (clear_i),
      .inc   (inc[k]),
      .cnt   (live[k]),
      .ovf   (ovf_o[k])
    );
  end

  assign cyc_nxt = CNT_W'(sat_inc(64'(live[CYCLE_IDX]), CNT_W));
  assign hit     = cnt_en && (limit_i != '0) && (cyc_nxt == limit_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_PAUSE: if (start_i) state_nxt = ST_RUN;
      ST_RUN:            if (!start_i) state_nxt = ST_PAUSE;
      default:           state_nxt = ST_DONE;
    endcase
    if (hit)     state_nxt = ST_DONE;
    if (clear_i) state_nxt = ST_IDLE;
  end

  assign state_o = state;
  assign done_o  = (state == ST_DONE);

  // Bank takes pre-increment register values, all entries on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       bank <= '0;
    else if (clear_i) bank <= '0;
    else if (snap_i)  bank <= live;
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k <= NUM_CH; k++)
      if (rd_idx_i == IDX_W'(k)) rd_mux = bank[k];
  end

  // Read sees the bank before any same-edge snapshot or clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= clear_i ? '0 : rd_mux;
    end
  end

`ifdef PERF_MON_THRESH_IRQ_EN
  logic [CNT_W-1:0] thr_mux;

  always_comb begin
    thr_mux = '0;
    for (int k = 0; k <= NUM_CH; k++)
      if (thresh_sel_i == IDX_W'(k)) thr_mux = live[k];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                     irq_o <= 1'b0;
    else if (clear_i)                               irq_o <= 1'b0;
    else if (thresh_i != '0 && thr_mux >= thresh_i) irq_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_perf_event_monitor.sv
// Self-checking bench for perf_event_monitor against a cycle-level behavioural model.
module tb_perf_event_monitor;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = $clog2(NUM_CH + 1);
  localparam int unsigned MAXV = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0, rst_i = 1'b0;
  logic              start_i = 1'b0, clear_i = 1'b0, snap_i = 1'b0, rd_en_i = 1'b0;
  logic [CNT_W-1:0]  limit_i = '0;
  logic [NUM_CH-1:0] event_i = '0;
  logic [IDX_W-1:0]  rd_idx_i = '0;
  logic [CNT_W-1:0]  rd_data_o;
  logic              rd_valid_o, done_o;
  logic [NUM_CH:0]   ovf_o;
  logic [1:0]        state_o;
`ifdef PERF_MON_THRESH_IRQ_EN
  logic [CNT_W-1:0]  thresh_i = '0;
  logic [IDX_W-1:0]  thresh_sel_i = '0;
  logic              irq_o;
`endif

  perf_event_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .limit_i(limit_i), .event_i(event_i), .snap_i(snap_i), .rd_en_i(rd_en_i),
    .rd_idx_i(rd_idx_i),
`ifdef PERF_MON_THRESH_IRQ_EN
    .thresh_i(thresh_i), .thresh_sel_i(thresh_sel_i), .irq_o(irq_o),
`endif
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .ovf_o(ovf_o),
    .state_o(state_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0, total = 0;

  // Model: counts as plain integers, state as a small int (0 idle,1 run,2 pause,3 done).
  int unsigned m_cnt [NUM_CH+1];
  int unsigned m_bank[NUM_CH+1];
  bit          m_ovf [NUM_CH+1];
  int          m_st;
  int unsigned m_rdd;
  bit          m_rdv;

  function automatic logic [NUM_CH:0] ovf_vec();
    logic [NUM_CH:0] r;
    for (int k = 0; k <= NUM_CH; k++) r[k] = m_ovf[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= NUM_CH; k++) begin
      m_cnt[k] = 0; m_bank[k] = 0; m_ovf[k] = 0;
    end
    m_st = 0; m_rdd = 0; m_rdv = 0;
  endtask

  // Advance the model by one edge using the currently driven inputs, then let the DUT take it.
  task automatic tick();
    bit en;
    m_rdv = rd_en_i;
    if (rd_en_i) m_rdd = clear_i ? 0 : ((rd_idx_i <= NUM_CH) ? m_bank[rd_idx_i] : 0);
    if (clear_i) begin
      for (int k = 0; k <= NUM_CH; k++) begin
        m_cnt[k] = 0; m_bank[k] = 0; m_ovf[k] = 0;
      end
      m_st = 0;
    end else begin
      if (snap_i) m_bank = m_cnt;
      en = start_i && (m_st != 3);
      if (en)
        for (int k = 0; k <= NUM_CH; k++)
          if (k == NUM_CH || event_i[k]) begin
            if (m_cnt[k] == MAXV) m_ovf[k] = 1;
            else                  m_cnt[k] = m_cnt[k] + 1;
          end
      if (m_st != 3) m_st = start_i ? 1 : ((m_st == 1) ? 2 : m_st);
      if (en && limit_i != 0 && m_cnt[NUM_CH] == limit_i) m_st = 3;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1; start_i = 1'b0; event_i = '0; limit_i = '0;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic do_snap();
    snap_i = 1'b1; tick(); snap_i = 1'b0;
  endtask

  task automatic do_read(input int idx);
    rd_en_i = 1'b1; rd_idx_i = IDX_W'(idx); tick(); rd_en_i = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (state_o !== 2'd0) $display("FAIL reset_state got %0d want 0", state_o); else passed++;
    total++; if (ovf_o !== '0) $display("FAIL reset_ovf got %b want 0", ovf_o); else passed++;
    total++; if (done_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_data_o !== '0)
      $display("FAIL reset_outs got done=%b vld=%b data=%0d want 0/0/0", done_o, rd_valid_o, rd_data_o); else passed++;
    rst_i = 1'b1;
    repeat (5) tick();
    total++; if (state_o !== 2'd0) $display("FAIL idle_state got %0d want 0", state_o); else passed++;
    for (int i = 0; i <= NUM_CH; i++) begin
      do_read(i);
      total++; if (rd_valid_o !== 1'b1 || rd_data_o !== CNT_W'(m_rdd))
        $display("FAIL idle_read%0d got vld=%b data=%0d want 1/%0d", i, rd_valid_o, rd_data_o, m_rdd); else passed++;
    end
  endtask

  task automatic test_basic();
    do_clear();
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      event_i = NUM_CH'({(i % 2 == 0), 1'b1});
      tick();
    end
    start_i = 1'b0; event_i = '0;
    do_snap();
    for (int j = 0; j < 3; j++) begin
      int idx;
      idx = (j == 2) ? NUM_CH : j;
      do_read(idx);
      total++; if (rd_valid_o !== 1'b1 || rd_data_o !== CNT_W'(m_rdd))
        $display("FAIL basic_read%0d got vld=%b data=%0d want 1/%0d", idx, rd_valid_o, rd_data_o, m_rdd); else passed++;
      tick();
      total++; if (rd_valid_o !== 1'b0 || rd_data_o !== CNT_W'(m_rdd))
        $display("FAIL basic_hold%0d got vld=%b data=%0d want 0/%0d", idx, rd_valid_o, rd_data_o, m_rdd); else passed++;
    end
  endtask

  task automatic test_limit();
    do_clear();
    limit_i = 8; start_i = 1'b1; event_i = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (done_o !== (m_st == 3)) $display("FAIL limit_done%0d got %b want %b", i, done_o, m_st == 3); else passed++;
    end
    total++; if (state_o !== 2'(m_st)) $display("FAIL limit_state got %0d want %0d", state_o, m_st); else passed++;
    repeat (20) tick();
    do_snap();
    do_read(NUM_CH);
    total++; if (rd_data_o !== CNT_W'(m_rdd)) $display("FAIL limit_cycle got %0d want %0d", rd_data_o, m_rdd); else passed++;
    do_read(2);
    total++; if (rd_data_o !== CNT_W'(m_rdd)) $display("FAIL limit_ch2 got %0d want %0d", rd_data_o, m_rdd); else passed++;
    total++; if (state_o !== 2'd3) $display("FAIL limit_stays got %0d want 3", state_o); else passed++;
  endtask

  task automatic test_pause();
    do_clear();
    start_i = 1'b1; repeat (3) tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (state_o !== 2'(m_st)) $display("FAIL pause_state%0d got %0d want %0d", i, state_o, m_st); else passed++;
    end
    start_i = 1'b1; repeat (2) tick();
    start_i = 1'b0;
    do_snap();
    do_read(NUM_CH);
    total++; if (rd_data_o !== CNT_W'(m_rdd)) $display("FAIL pause_cycle got %0d want %0d", rd_data_o, m_rdd); else passed++;
  endtask

  task automatic test_saturation();
    do_clear();
    start_i = 1'b1; event_i = 4'b1000;
    repeat (300) tick();
    do_snap();
    do_read(3);
    total++; if (rd_data_o !== CNT_W'(m_rdd)) $display("FAIL sat_ch3 got %0d want %0d", rd_data_o, m_rdd); else passed++;
    total++; if (ovf_o !== ovf_vec()) $display("FAIL sat_ovf got %b want %b", ovf_o, ovf_vec()); else passed++;
    start_i = 1'b0; event_i = '0;
    repeat (5) tick();
    total++; if (ovf_o !== ovf_vec()) $display("FAIL sat_sticky got %b want %b", ovf_o, ovf_vec()); else passed++;
    do_clear();
    do_snap();
    do_read(3);
    total++; if (rd_data_o !== CNT_W'(m_rdd) || ovf_o !== '0 || state_o !== 2'd0)
      $display("FAIL sat_clear got data=%0d ovf=%b st=%0d want %0d/0/0", rd_data_o, ovf_o, state_o, m_rdd); else passed++;
  endtask

  task automatic test_collision();
    do_clear();
    start_i = 1'b1; event_i = 4'b0001;
    repeat (3) tick();
    do_snap();
    repeat (2) tick();
    snap_i = 1'b1; do_read(0); snap_i = 1'b0;
    total++; if (rd_data_o !== CNT_W'(m_rdd)) $display("FAIL coll_old got %0d want %0d", rd_data_o, m_rdd); else passed++;
    do_read(0);
    total++; if (rd_data_o !== CNT_W'(m_rdd)) $display("FAIL coll_new got %0d want %0d", rd_data_o, m_rdd); else passed++;
    clear_i = 1'b1; snap_i = 1'b1; do_read(0); clear_i = 1'b0; snap_i = 1'b0;
    total++; if (rd_data_o !== CNT_W'(m_rdd) || rd_valid_o !== 1'b1)
      $display("FAIL coll_clr_rd got data=%0d vld=%b want %0d/1", rd_data_o, rd_valid_o, m_rdd); else passed++;
    start_i = 1'b0; event_i = '0;
    do_read(0);
    total++; if (rd_data_o !== CNT_W'(m_rdd)) $display("FAIL coll_clr_bank got %0d want %0d", rd_data_o, m_rdd); else passed++;
    do_read(7);
    total++; if (rd_data_o !== '0 || rd_valid_o !== 1'b1)
      $display("FAIL oob_read got data=%0d vld=%b want 0/1", rd_data_o, rd_valid_o); else passed++;
  endtask

  task automatic test_reset_in_run();
    do_clear();
    start_i = 1'b1; event_i = 4'b1111;
    repeat (5) tick();
    #2 rst_i = 1'b0;
    #1;
    total++; if (state_o !== 2'd0 || ovf_o !== '0 || done_o !== 1'b0 || rd_data_o !== '0)
      $display("FAIL rst_run got st=%0d ovf=%b done=%b data=%0d want 0", state_o, ovf_o, done_o, rd_data_o); else passed++;
    start_i = 1'b0; event_i = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    model_reset();
    start_i = 1'b1; tick(); start_i = 1'b0;
    do_snap();
    do_read(NUM_CH);
    total++; if (rd_data_o !== CNT_W'(m_rdd)) $display("FAIL rst_run_cycle got %0d want %0d", rd_data_o, m_rdd); else passed++;
  endtask

  task automatic test_random();
    do_clear();
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 0) limit_i = ($urandom % 3 == 0) ? '0 : CNT_W'($urandom_range(1, 120));
      start_i  = ($urandom % 4) != 0;
      event_i  = NUM_CH'($urandom);
      snap_i   = ($urandom % 5) == 0;
      rd_en_i  = $urandom % 2;
      rd_idx_i = IDX_W'($urandom % 8);
      clear_i  = ($urandom % 70) == 0;
      tick();
      total++; if (state_o !== 2'(m_st) || done_o !== (m_st == 3))
        $display("FAIL rnd_state@%0d got %0d/%b want %0d", i, state_o, done_o, m_st); else passed++;
      total++; if (ovf_o !== ovf_vec()) $display("FAIL rnd_ovf@%0d got %b want %b", i, ovf_o, ovf_vec()); else passed++;
      total++; if (rd_valid_o !== m_rdv || rd_data_o !== CNT_W'(m_rdd))
        $display("FAIL rnd_rd@%0d got vld=%b data=%0d want %b/%0d", i, rd_valid_o, rd_data_o, m_rdv, m_rdd); else passed++;
    end
    clear_i = 1'b0; snap_i = 1'b0; rd_en_i = 1'b0; start_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limit();
    test_pause();
    test_saturation();
    test_collision();
    test_reset_in_run();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
- Synthesizable pipeline performance monitor that replaces the stall/flush counting currently done in simulation.
- Counts per-cycle event pulses (stall, flush, retire, branch, …) over NUM_CH channels plus a free cycle counter, bounded by a programmable cycle limit.
- Provides an atomic snapshot bank and an indexed read port, so counts can be sampled in silicon without perturbing the running counters.
- Instantiated beside the CPU pipeline; event inputs are single-cycle flags taken from the hazard/flush logic.

Parameters:
- NUM_CH, 4, number of event channels (1..16).
- CNT_W, 32, width of every counter, including the cycle counter (8..64).
- IDX_W, $clog2(NUM_CH+1), read-index width; derived, never overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  level enable; counting runs while high.
- clear_i  in  1  synchronous clear of all counters, flags, snapshot and FSM.
- limit_i  in  CNT_W  cycle limit; 0 = unlimited; sampled every cycle.
- event_i  in  NUM_CH  per-channel event pulse, one count per high cycle.
- snap_i  in  1  copy live counters into the snapshot bank.
- rd_en_i  in  1  read request.
- rd_idx_i  in  IDX_W  0..NUM_CH-1 selects a channel; NUM_CH selects the cycle counter.
- rd_data_o  out  CNT_W  snapshot value.
- rd_valid_o  out  1  rd_data_o valid.
- ovf_o  out  NUM_CH+1  sticky saturation flags; bit NUM_CH belongs to the cycle counter.
- state_o  out  2  FSM state.
- done_o  out  1  limit reached.

Behaviour:
- Reset (rst_i=0, asynchronous): all counters, snapshot bank, ovf_o, rd_data_o, rd_valid_o and done_o = 0; state = IDLE.
- State encodings: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- IDLE -> RUN when start_i=1; counting starts on the same edge.
- RUN -> PAUSE when start_i=0; PAUSE -> RUN when start_i=1. In PAUSE the counters hold.
- RUN -> DONE when limit_i!=0 and the cycle counter's next value equals limit_i. The limit cycle is counted, including its events.
- DONE: counters frozen; done_o=1; leaves only on clear_i or reset.
- limit_i already <= the current cycle count while in RUN: the limit is never hit and counting continues.
- Counting in RUN, per edge:
  - cycle counter += 1.
  - ch[k] += event_i[k].
- Saturation: a counter at all-ones stays at all-ones, and the matching ovf bit is set when an increment is attempted. ovf bits are sticky until clear_i or reset.
- Snapshot: on an edge with snap_i=1, the bank captures the register values present before that edge's increment. All NUM_CH+1 entries are captured atomically. Snapshot is allowed in any state.
- Read: rd_en_i at edge N gives rd_valid_o=1 and rd_data_o = bank[rd_idx_i] after edge N+1 (1-cycle latency).
  - rd_valid_o is a single-cycle pulse per request; back-to-back requests are allowed.
  - rd_data_o holds its last value when rd_valid_o=0.
- Simultaneous snap_i and rd_en_i: the read returns the old bank contents.
- Out-of-range rd_idx_i (> NUM_CH): rd_data_o=0, rd_valid_o=1.
- clear_i has top priority over start_i, snap_i and the limit. It zeroes counters, bank and ovf_o, drops done_o and sets state = IDLE. rd_en_i in the same cycle returns 0.
- Reset during RUN: immediate return to IDLE with all values zero; no partial-count retention.

Optional Feature:
- Macro PERF_MON_THRESH_IRQ_EN.
- When defined:
  - Extra input thresh_i (CNT_W) and thresh_sel_i (IDX_W).
  - Extra output irq_o (1). irq_o is set the cycle after the selected live counter first becomes >= thresh_i (non-zero thresh_i only).
  - irq_o is sticky until clear_i or reset.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package perf_mon_pkg holds:
  - state encodings (IDLE/RUN/PAUSE/DONE);
  - the read-index constant CYCLE_IDX = NUM_CH convention;
  - a saturating-increment function.
- One natural sub-module, perf_sat_counter: a CNT_W saturating counter with inc, clr and sticky ovf. Instantiate it NUM_CH+1 times.
- The FSM, snapshot bank and read mux stay in the top module.

Test Plan:
- Reset/idle: hold rst_i=0 then release, start_i=0 for 5 cycles -> state_o=0, all reads return 0, ovf_o=0.
- Basic count: NUM_CH=4, start_i=1 for 10 cycles, event_i[0] high on every cycle, event_i[1] on alternate cycles, then snap_i and read idx 0,1,4 -> 10, 5, 10, each rd_valid_o one cycle after its request.
- Limit: limit_i=8, start_i=1 held, event_i[2] constant high -> done_o=1 after the 8th counted edge, state_o=3; snapshot reads cycle=8 and ch2=8; counts unchanged 20 cycles later.
- Pause: count 3 cycles, start_i=0 for 4 cycles, then 2 more cycles -> cycle counter = 5, state_o=2 during the gap.
- Saturation: CNT_W=8, event_i[3] high for 300 cycles -> ch3 reads 255, ovf_o[3]=1 and stays set; clear_i -> ch3 reads 0, ovf_o=0, state_o=0.
- Collision: snap_i and rd_en_i (idx 0) on the same edge while counting -> returns the previous snapshot; the next read returns the new value. clear_i together with snap_i -> bank reads 0.
